// File: rtl/prco_uart_tx.sv
// Debug UART transmitter: buffers core writes in a small FIFO, stalls the core when full, and serialises 8N1, LSB first.
// Define PRCO_UART_TX_PARITY_EN to insert an even-parity bit after the data bits (8E1).
module prco_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_AW      = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_en,
  input  logic               i_ce,
  input  logic [7:0]         i_data,
  output logic               q_stall,
  output logic               q_busy,
  output logic               q_tx,
  output logic [FIFO_AW:0]   q_count
);

  localparam int DEPTH  = 2 ** FIFO_AW;
  localparam int CW     = FIFO_AW + 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0]  BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]      FULL      = CW'(DEPTH);
  localparam logic [CW-1:0]      CNT_ONE   = CW'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
  localparam logic [BAUD_W-1:0]  BAUD_ONE  = BAUD_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic                 tx_q, tx_d;
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [7:0]           shift_q, shift_d;
`ifdef PRCO_UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic [7:0]           mem_q [DEPTH];
  logic                 push;
  logic                 pop;
  logic                 baud_last;
  logic                 start_ok;
  logic [7:0]           fifo_head;

  assign q_stall   = (count_q == FULL);
  assign q_busy    = (state_q != S_IDLE) || (count_q != '0);
  assign q_tx      = tx_q;
  assign q_count   = count_q;

  assign push      = i_ce && !q_stall;
  assign baud_last = (baud_q == BAUD_LAST);
  assign start_ok  = i_en && (count_q != '0);
  assign fifo_head = mem_q[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    shift_d  = shift_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop      = 1'b0;
`ifdef PRCO_UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (start_ok) begin
          pop     = 1'b1;
          state_d = S_START;
          baud_d  = '0;
          tx_d    = 1'b0;
        end
      end

      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef PRCO_UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = parity_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

`ifdef PRCO_UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
`endif

      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next start bit so queued bytes leave with no idle gap.
          if (start_ok) begin
            pop     = 1'b1;
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase

    if (pop) begin
      shift_d  = fifo_head;
      rd_ptr_d = rd_ptr_q + PTR_ONE;
`ifdef PRCO_UART_TX_PARITY_EN
      parity_d = ^fifo_head;
`endif
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    // Stall comes from the registered count, so a pop never frees a slot within the same cycle.
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Datapath storage carries no reset; it is only ever read after being written.
  always_ff @(posedge i_clk) begin
    shift_q <= shift_d;
`ifdef PRCO_UART_TX_PARITY_EN
    parity_q <= parity_d;
`endif
    if (push) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

endmodule

// File: tb/tb_prco_uart_tx.sv
// Self-checking bench for prco_uart_tx (CLKS_PER_BIT=4, FIFO_AW=2): table-driven frames plus burst, enable and reset sequences.
module tb_prco_uart_tx;

  localparam int CPB = 4;
  localparam int AW  = 2;
`ifdef PRCO_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic          i_clk   = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_en    = 1'b0;
  logic          i_ce    = 1'b0;
  logic [7:0]    i_data  = 8'h00;
  logic          q_stall;
  logic          q_busy;
  logic          q_tx;
  logic [AW:0]   q_count;

  prco_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (i_en),
    .i_ce    (i_ce),
    .i_data  (i_data),
    .q_stall (q_stall),
    .q_busy  (q_busy),
    .q_tx    (q_tx),
    .q_count (q_count)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Line-order frame bits: bit 0 is the start bit, the last bit is the stop bit.
  typedef struct {
    logic [7:0]  data;
    logic [9:0]  frame_n1;
    logic [10:0] frame_e1;
  } vec_t;

  vec_t vecs [6];

  // Background receiver: samples mid-bit and queues decoded bytes.
  logic [7:0] rx_q [$];

  initial begin : rx_mon
    logic [7:0] b;
    forever begin
      @(negedge i_clk);
      if (!i_reset && q_tx === 1'b0) begin
        repeat (2) @(negedge i_clk);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge i_clk);
          b[k] = q_tx;
        end
`ifdef PRCO_UART_TX_PARITY_EN
        repeat (CPB) @(negedge i_clk);
`endif
        repeat (CPB) @(negedge i_clk);
        rx_q.push_back(b);
      end
    end
  end

  function automatic logic [7:0] rx_at(input int k);
    if (k < rx_q.size()) return rx_q[k];
    return 8'hxx;
  endfunction

  // Called at a falling edge; holds i_ce until the byte is accepted on a rising edge.
  task automatic push_byte(input logic [7:0] b);
    int w;
    w = 0;
    i_ce   = 1'b1;
    i_data = b;
    while (q_stall === 1'b1 && w < 200) begin
      @(negedge i_clk);
      w++;
    end
    if (w >= 200) begin
      checks++;
      errors++;
      $display("FAIL push_wait: stall held %0d cycles, required release before 200", w);
    end
    @(posedge i_clk);
    @(negedge i_clk);
    i_ce = 1'b0;
  endtask

  initial begin
    int bad;
    int w;
    logic [10:0] fr;
    logic [AW:0] cnt_exp [5];
    logic        stall_exp [5];

    vecs[0] = '{8'hA5, 10'b1_10100101_0, 11'b1_0_10100101_0};
    vecs[1] = '{8'h00, 10'b1_00000000_0, 11'b1_0_00000000_0};
    vecs[2] = '{8'hFF, 10'b1_11111111_0, 11'b1_0_11111111_0};
    vecs[3] = '{8'h07, 10'b1_00000111_0, 11'b1_1_00000111_0};
    vecs[4] = '{8'h03, 10'b1_00000011_0, 11'b1_0_00000011_0};
    vecs[5] = '{8'h80, 10'b1_10000000_0, 11'b1_1_10000000_0};
    cnt_exp   = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    stall_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset before any clock edge
    #1 i_reset = 1'b1;
    #1;
    chk("rst_tx", q_tx, 1);
    chk("rst_stall", q_stall, 0);
    chk("rst_busy", q_busy, 0);
    chk("rst_count", q_count, 0);
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    i_en    = 1'b1;
    @(negedge i_clk);

    // Single frames from the table
    for (int v = 0; v < 6; v++) begin
`ifdef PRCO_UART_TX_PARITY_EN
      fr = vecs[v].frame_e1;
`else
      fr = {1'b0, vecs[v].frame_n1};
`endif
      i_ce   = 1'b1;
      i_data = vecs[v].data;
      @(posedge i_clk);
      @(negedge i_clk);
      i_ce = 1'b0;
      chk($sformatf("v%0d_tx_before_start", v), q_tx, 1);
      chk($sformatf("v%0d_count_after_accept", v), q_count, 1);
      @(negedge i_clk);
      chk($sformatf("v%0d_busy_in_frame", v), q_busy, 1);
      bad = 0;
      for (int i = 0; i < NB; i++) begin
        for (int c = 0; c < CPB; c++) begin
          if (q_tx !== fr[i]) bad++;
          @(negedge i_clk);
        end
      end
      chk($sformatf("v%0d_frame_%02h_bad_samples", v, vecs[v].data), bad, 0);
      chk($sformatf("v%0d_busy_after_frame", v), q_busy, 0);
      chk($sformatf("v%0d_tx_idle", v), q_tx, 1);
    end

    // Burst: six writes into a four-deep FIFO while the first frame drains
    rx_q.delete();
    for (int k = 0; k < 5; k++) begin
      push_byte(8'(k + 1));
      chk($sformatf("burst_count_%0d", k + 1), q_count, cnt_exp[k]);
      chk($sformatf("burst_stall_%0d", k + 1), q_stall, stall_exp[k]);
    end
    push_byte(8'h06);
    w = 0;
    while (rx_q.size() < 6 && w < 800) begin
      @(negedge i_clk);
      w++;
    end
    chk("burst_rx_count", rx_q.size(), 6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("burst_byte_%0d", k), rx_at(k), k + 1);
    end
    w = 0;
    while (q_busy === 1'b1 && w < 50) begin
      @(negedge i_clk);
      w++;
    end
    chk("burst_busy_end", q_busy, 0);
    chk("burst_count_end", q_count, 0);

    // Enable gating: writes accepted while disabled, frame starts one cycle after enable
    rx_q.delete();
    i_en = 1'b0;
    push_byte(8'h3C);
    chk("en0_count", q_count, 1);
    bad = 0;
    repeat (12) begin
      if (q_tx !== 1'b1) bad++;
      @(negedge i_clk);
    end
    chk("en0_tx_held_high", bad, 0);
    chk("en0_busy", q_busy, 1);
    i_en = 1'b1;
    @(negedge i_clk);
    chk("en1_start_bit", q_tx, 0);
    push_byte(8'h5A);
    i_en = 1'b0;
    repeat (NB * CPB + 4) @(negedge i_clk);
    chk("en_mid_rx_count", rx_q.size(), 1);
    chk("en_mid_rx_byte", rx_at(0), 8'h3C);
    chk("en_mid_count_held", q_count, 1);
    bad = 0;
    repeat (20) begin
      if (q_tx !== 1'b1) bad++;
      @(negedge i_clk);
    end
    chk("en_mid_next_held", bad, 0);
    i_en = 1'b1;
    w = 0;
    while (rx_q.size() < 2 && w < 200) begin
      @(negedge i_clk);
      w++;
    end
    chk("en_resume_byte", rx_at(1), 8'h5A);
    repeat (8) @(negedge i_clk);

    // Reset in the middle of the data bits of 0xFF with another byte queued
    push_byte(8'hFF);
    push_byte(8'h11);
    repeat (CPB + 8) @(negedge i_clk);
    chk("pre_rst_tx_data_bit", q_tx, 1);
    chk("pre_rst_busy", q_busy, 1);
    #2 i_reset = 1'b1;
    #1;
    chk("mid_rst_tx", q_tx, 1);
    chk("mid_rst_count", q_count, 0);
    chk("mid_rst_busy", q_busy, 0);
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    bad = 0;
    repeat (60) begin
      if (q_tx !== 1'b1) bad++;
      @(negedge i_clk);
    end
    chk("post_rst_no_frame", bad, 0);
    chk("post_rst_count", q_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
